// File: rtl/tnn_pkg.sv
// Shared constants and types for the TNN feature packer.
// Holds widths, default thresholds, the 2-bit code type and collect-state enum.
package tnn_pkg;

  localparam int NUM_FEATURES = 7;
  localparam int CODE_W = 2;
  localparam int VEC_W = 14;
  localparam int RAW_W = 8;

  localparam logic [RAW_W-1:0] T0_DEF = 8'd64;
  localparam logic [RAW_W-1:0] T1_DEF = 8'd128;
  localparam logic [RAW_W-1:0] T2_DEF = 8'd192;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [RAW_W-1:0] raw_t;

  typedef enum logic {
    COLLECT,
    LASTBEAT
  } cstate_t;

endpackage

// File: rtl/tnn_quantizer2b.sv
// Combinational 2-bit quantizer: x against thresholds t0/t1/t2.
// Ports: x, t0, t1, t2 (unsigned raw) in; code (code_t) out.
module tnn_quantizer2b
  import tnn_pkg::*;
(
  input  raw_t  x,
  input  raw_t  t0,
  input  raw_t  t1,
  input  raw_t  t2,
  output code_t code
);

  // Priority chain: thresholds are not required to be ordered.
  always_comb begin
    code = 2'd3;
    if (x < t0) code = 2'd0;
    else if (x < t1) code = 2'd1;
    else if (x < t2) code = 2'd2;
  end

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantizes 8-bit features to 2-bit codes and packs 7 into a 14-bit vector.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_vec,
// err, err_cnt; cfg_we/cfg_sel/cfg_data only with TNN_PACKER_THRESH_CFG_EN.
module tnn_feature_packer
  import tnn_pkg::*;
#(
  parameter raw_t T0 = T0_DEF,
  parameter raw_t T1 = T1_DEF,
  parameter raw_t T2 = T2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RAW_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic             err,
  output logic [7:0]       err_cnt
`ifdef TNN_PACKER_THRESH_CFG_EN
  ,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [RAW_W-1:0] cfg_data
`endif
);

  raw_t th0, th1, th2;

`ifdef TNN_PACKER_THRESH_CFG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th0 <= T0;
      th1 <= T1;
      th2 <= T2;
    end else if (cfg_we) begin
      unique case (cfg_sel)
        2'd0: th0 <= cfg_data;
        2'd1: th1 <= cfg_data;
        2'd2: th2 <= cfg_data;
        default: ;
      endcase
    end
  end
`else
  assign th0 = T0;
  assign th1 = T1;
  assign th2 = T2;
`endif

  code_t code;

  tnn_quantizer2b u_quant (
    .x    (in_data),
    .t0   (th0),
    .t1   (th1),
    .t2   (th2),
    .code (code)
  );

  logic [2:0] cnt, cnt_nx;
  code_t [NUM_FEATURES-2:0] slots;
  cstate_t st;
  logic acc, load, bad, store;

  assign acc = in_valid & in_ready;

  always_comb begin
    st = (cnt == 3'd6) ? LASTBEAT : COLLECT;
    in_ready = 1'b1;
    cnt_nx = cnt;
    load = 1'b0;
    bad = 1'b0;
    store = 1'b0;
    unique case (st)
      COLLECT: begin
        if (acc) begin
          if (in_last) begin
            bad = 1'b1;
            cnt_nx = 3'd0;
          end else begin
            store = 1'b1;
            cnt_nx = cnt + 3'd1;
          end
        end
      end
      LASTBEAT: begin
        // Last beat stalls only while a vector is waiting to drain.
        in_ready = !out_valid | out_ready;
        if (acc) begin
          cnt_nx = 3'd0;
          if (in_last) load = 1'b1;
          else bad = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 3'd0;
      slots <= '0;
    end else begin
      cnt <= cnt_nx;
      if (store) slots[cnt] <= code;
    end
  end

  // Slot 6 comes straight from the quantizer on the closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_vec <= {code, slots};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= bad;
      if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Scoreboard bench for tnn_feature_packer.
// Directed samples push expected vectors; a negedge monitor pops and compares.
module tb_tnn_feature_packer;
  import tnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic in_ready, out_valid, err;
  logic [13:0] out_vec;
  logic [7:0] err_cnt;
`ifdef TNN_PACKER_THRESH_CFG_EN
  logic cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_data = 8'd0;
`endif

  tnn_feature_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .err       (err),
    .err_cnt   (err_cnt)
`ifdef TNN_PACKER_THRESH_CFG_EN
    ,
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [13:0] exp_q[$];
  logic [7:0] tbl[3][7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", out_vec);
      end else begin
        chk("out_vec", {18'd0, out_vec}, {18'd0, exp_q[0]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_sample(input int s, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = tbl[s][i];
      in_last = (i == last_idx);
      wait_accept();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{8'd10, 8'd70, 8'd130, 8'd200, 8'd0, 8'd255, 8'd127};
    tbl[1] = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    tbl[2] = '{8'd5, 8'd15, 8'd25, 8'd35, 8'd10, 8'd20, 8'd30};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    exp_q.push_back(14'h1CE4);
    send_sample(0, 7, 6);
    chk("latency_valid", out_valid, 1);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", out_valid, 0);

    exp_q.push_back(14'h3E94);
    send_sample(1, 7, 6);
    drain();
    chk("delivered_2", delivered, 2);

    out_ready = 1'b0;
    exp_q.push_back(14'h1CE4);
    exp_q.push_back(14'h3E94);
    send_sample(0, 7, 6);
    send_sample(1, 6, -1);
    in_valid = 1'b1;
    in_data = tbl[1][6];
    in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_stall", in_ready, 0);
    end
    chk("held_no_drain", delivered, 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();
    chk("delivered_4", delivered, 4);

    send_sample(0, 3, 2);
    chk("short_err", err, 1);
    chk("short_err_cnt", err_cnt, 1);
    @(posedge clk);
    #1;
    chk("err_pulse_end", err, 0);
    exp_q.push_back(14'h1CE4);
    send_sample(0, 7, 6);
    drain();
    send_sample(1, 7, -1);
    chk("long_err", err, 1);
    chk("long_err_cnt", err_cnt, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("delivered_5", delivered, 5);

    send_sample(0, 4, -1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_vec", out_vec, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(14'h3E94);
    send_sample(1, 7, 6);
    chk("post_rst_err", err, 0);
    drain();
    chk("post_rst_err_cnt", err_cnt, 0);

`ifdef TNN_PACKER_THRESH_CFG_EN
    cfg_we = 1'b1;
    cfg_sel = 2'd0;
    cfg_data = 8'd10;
    @(posedge clk);
    #1;
    cfg_sel = 2'd1;
    cfg_data = 8'd20;
    @(posedge clk);
    #1;
    cfg_sel = 2'd2;
    cfg_data = 8'd30;
    @(posedge clk);
    #1;
    cfg_sel = 2'd3;
    cfg_data = 8'd0;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    exp_q.push_back(14'h39E4);
    send_sample(2, 7, 6);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
